// File: rtl/mem_stream_seq.sv
// Streams up to NCH per-channel memories onto one bus, one entry per clock, skipping empty channels.
// Latency: rd_en at cycle N -> out_valid at N+RD_LAT+1; event length 2+sum(count)+RD_LAT+1 cycles.
// Backpressure: none; the stream is gap-free and the sink must accept every cycle.
module mem_stream_seq #(
    parameter int NCH    = 24,
    parameter int DW     = 12,
    parameter int AW     = 6,
    parameter int RD_LAT = 2,
    parameter int CW     = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [NCH*(AW+1)-1:0]   nent_flat,
    input  logic [NCH*DW-1:0]       mem_dat_flat,
    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr,
    output logic [DW-1:0]           out_dat,
    output logic                    out_valid,
    output logic [CW-1:0]           out_ch,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    overlap_err
);

    localparam logic [AW:0] MAXCNT = {1'b1, {AW{1'b0}}};
    localparam int          DCW    = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_READ, S_DRAIN, S_DONE} state_t;

    state_t             state, state_n;
    logic [AW:0]        cnt [NCH];
    logic [AW:0]        cnt_in [NCH];
    logic [NCH-1:0]     pending, pending_n, pending_in, cur_bit, search;
    logic [CW-1:0]      cur_ch, cur_ch_n, next_ch;
    logic               found;
    logic [AW-1:0]      addr, addr_n;
    logic [AW:0]        cur_cnt_m1;
    logic               at_end;
    logic [DCW-1:0]     drain_cnt, drain_cnt_n;
    logic               last_rd;

    logic               tag_vld  [RD_LAT];
    logic [CW-1:0]      tag_ch   [RD_LAT];
    logic               tag_last [RD_LAT];
    logic [CW-1:0]      sel_ch;

    assign rd_en   = (state == S_READ);
    assign rd_addr = addr;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign sel_ch  = tag_ch[RD_LAT-1];

    // Counts above 2^AW are clamped so the address never wraps.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_in[i]     = (nent_flat[i*(AW+1) +: AW+1] > MAXCNT) ? MAXCNT
                                                                  : nent_flat[i*(AW+1) +: AW+1];
            pending_in[i] = |nent_flat[i*(AW+1) +: AW+1];
            cur_bit[i]    = (cur_ch == CW'(i));
        end
    end

    // In READ the current channel is excluded so the successor is known before its final read.
    always_comb begin
        search  = (state == S_READ) ? (pending & ~cur_bit) : pending;
        found   = 1'b0;
        next_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (search[i]) begin
                found   = 1'b1;
                next_ch = CW'(i);
            end
        end
    end

    assign cur_cnt_m1 = cnt[cur_ch] - (AW+1)'(1);
    assign at_end     = (addr == cur_cnt_m1[AW-1:0]);

    always_comb begin
        state_n     = state;
        pending_n   = pending;
        cur_ch_n    = cur_ch;
        addr_n      = addr;
        drain_cnt_n = drain_cnt;
        last_rd     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pending_n = pending_in;
                    state_n   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (found) begin
                    cur_ch_n = next_ch;
                    addr_n   = '0;
                    state_n  = S_READ;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_READ: begin
                if (at_end) begin
                    pending_n = pending & ~cur_bit;
                    if (found) begin
                        cur_ch_n = next_ch;
                        addr_n   = '0;
                    end else begin
                        last_rd     = 1'b1;
                        drain_cnt_n = '0;
                        state_n     = S_DRAIN;
                    end
                end else begin
                    addr_n = addr + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DCW'(RD_LAT)) state_n = S_DONE;
                else                           drain_cnt_n = drain_cnt + DCW'(1);
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pending     <= '0;
            cur_ch      <= '0;
            addr        <= '0;
            drain_cnt   <= '0;
            overlap_err <= 1'b0;
            out_valid   <= 1'b0;
            out_dat     <= '0;
            out_ch      <= '0;
            out_last    <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_vld[k]  <= 1'b0;
                tag_ch[k]   <= '0;
                tag_last[k] <= 1'b0;
            end
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            cur_ch      <= cur_ch_n;
            addr        <= addr_n;
            drain_cnt   <= drain_cnt_n;
            overlap_err <= start && (state != S_IDLE);
            if (state == S_IDLE && start) begin
                for (int i = 0; i < NCH; i++) cnt[i] <= cnt_in[i];
            end

            tag_vld[0]  <= rd_en;
            tag_ch[0]   <= cur_ch;
            tag_last[0] <= last_rd;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k]  <= tag_vld[k-1];
                tag_ch[k]   <= tag_ch[k-1];
                tag_last[k] <= tag_last[k-1];
            end

            // Tag reaches the end of the line in the cycle memory data is valid.
            out_valid <= tag_vld[RD_LAT-1];
            out_last  <= tag_vld[RD_LAT-1] && tag_last[RD_LAT-1];
            if (tag_vld[RD_LAT-1]) begin
                out_ch <= sel_ch;
                if (int'(sel_ch) < NCH) out_dat <= mem_dat_flat[sel_ch*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_seq.sv
// Bench for mem_stream_seq: memory model returns {channel, address}; scoreboard checks reads and stream.
module tb_mem_stream_seq;

    localparam int NCH    = 24;
    localparam int DW     = 12;
    localparam int AW     = 6;
    localparam int RD_LAT = 2;
    localparam int CW     = 5;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] dat;
        logic          last;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [NCH*(AW+1)-1:0] nent_flat = '0;
    logic [NCH*DW-1:0]     mem_dat_flat;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DW-1:0]         out_dat;
    logic                  out_valid;
    logic [CW-1:0]         out_ch;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  overlap_err;

    mem_stream_seq #(.NCH(NCH), .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .nent_flat(nent_flat),
        .mem_dat_flat(mem_dat_flat), .rd_en(rd_en), .rd_addr(rd_addr), .out_dat(out_dat),
        .out_valid(out_valid), .out_ch(out_ch), .out_last(out_last), .busy(busy),
        .done(done), .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with RD_LAT cycles of latency from the shared address.
    logic [AW-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= rd_addr;
        a2 <= a1;
    end
    always_comb begin
        for (int i = 0; i < NCH; i++) mem_dat_flat[i*DW +: DW] = {6'(i), a2};
    end

    int   total = 0;
    int   bad = 0;
    int   cfg [NCH];
    int   exp_rd [$];
    ent_t exp_out [$];
    int   t0, rd_cnt, out_cnt, first_rd, last_rd, first_out, last_out, last_cyc;
    int   done_cnt, done_cyc, busy_cnt, ovl_cnt, ovl_cyc;

    always @(negedge clk) begin
        if (rd_en) begin
            int ea;
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected cyc=%0d addr=%0d required=no read", cyc, rd_addr);
            end else begin
                ea = exp_rd.pop_front();
                if (rd_addr !== AW'(ea)) begin
                    bad++;
                    $display("FAIL rd_addr cyc=%0d got=%0d required=%0d", cyc, rd_addr, ea);
                end
            end
        end
        if (out_valid) begin
            ent_t e;
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            total++;
            if (exp_out.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected cyc=%0d ch=%0d dat=%h required=no output", cyc, out_ch, out_dat);
            end else begin
                e = exp_out.pop_front();
                if ({out_ch, out_dat, out_last} !== e) begin
                    bad++;
                    $display("FAIL out_entry cyc=%0d got ch=%0d dat=%h last=%0b required ch=%0d dat=%h last=%0b",
                             cyc, out_ch, out_dat, out_last, e.ch, e.dat, e.last);
                end
            end
        end
        if (out_last) last_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if (overlap_err) begin ovl_cnt++; ovl_cyc = cyc; end
    end

    function automatic int clampi(input int c);
        return (c > (1 << AW)) ? (1 << AW) : c;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < NCH; i++) cfg[i] = 0;
    endtask

    // Called at a negedge; start is sampled at the following posedge, so the event's T is t0.
    task automatic launch();
        int n_all, k;
        ent_t e;
        n_all = 0;
        k = 0;
        for (int i = 0; i < NCH; i++) n_all += clampi(cfg[i]);
        for (int i = 0; i < NCH; i++) begin
            for (int a = 0; a < clampi(cfg[i]); a++) begin
                exp_rd.push_back(a);
                e.ch   = CW'(i);
                e.dat  = DW'((i << AW) | a);
                e.last = (k == n_all - 1);
                exp_out.push_back(e);
                k++;
            end
            nent_flat[i*(AW+1) +: AW+1] = (AW+1)'(cfg[i]);
        end
        rd_cnt = 0; out_cnt = 0; first_rd = -1; last_rd = -1; first_out = -1; last_out = -1;
        last_cyc = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0; ovl_cnt = 0; ovl_cyc = -1;
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1; break; end
        end
        #1;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL done_timeout got=no done required=done within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rd_en, out_valid, out_last, busy, done, overlap_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=000000", {rd_en, out_valid, out_last, busy, done, overlap_err});
        end
        total++;
        if ({rd_addr, out_dat, out_ch} !== '0) begin
            bad++;
            $display("FAIL reset_bus got addr=%0d dat=%h ch=%0d required=0", rd_addr, out_dat, out_ch);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({rd_en, out_valid, busy, done} !== 4'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b required=0000", {rd_en, out_valid, busy, done});
        end
    endtask

    task automatic test_single();
        clear_cfg();
        cfg[0] = 3;
        launch();
        wait_done(40);
        total++;
        if (first_rd !== t0 + 2 || rd_cnt !== 3) begin
            bad++;
            $display("FAIL single_rd got first=%0d n=%0d required first=%0d n=3", first_rd, rd_cnt, t0 + 2);
        end
        total++;
        if (first_out !== t0 + 5 || out_cnt !== 3) begin
            bad++;
            $display("FAIL single_out got first=%0d n=%0d required first=%0d n=3", first_out, out_cnt, t0 + 5);
        end
        total++;
        if (last_cyc !== t0 + 7) begin
            bad++;
            $display("FAIL single_last got=%0d required=%0d", last_cyc, t0 + 7);
        end
        total++;
        if (done_cyc !== t0 + 8 || done_cnt !== 1) begin
            bad++;
            $display("FAIL single_done got cyc=%0d n=%0d required cyc=%0d n=1", done_cyc, done_cnt, t0 + 8);
        end
    endtask

    task automatic test_back_to_back();
        clear_cfg();
        cfg[1] = 2; cfg[5] = 1; cfg[23] = 1;
        launch();
        wait_done(40);
        total++;
        if (rd_cnt !== 4 || last_rd - first_rd + 1 !== 4) begin
            bad++;
            $display("FAIL b2b_rd got n=%0d span=%0d required n=4 span=4", rd_cnt, last_rd - first_rd + 1);
        end
        total++;
        if (out_cnt !== 4 || last_out - first_out + 1 !== 4 || first_out !== t0 + 5) begin
            bad++;
            $display("FAIL b2b_out got n=%0d span=%0d first=%0d required n=4 span=4 first=%0d",
                     out_cnt, last_out - first_out + 1, first_out, t0 + 5);
        end
        total++;
        if (done_cyc !== t0 + 9) begin
            bad++;
            $display("FAIL b2b_done got=%0d required=%0d", done_cyc, t0 + 9);
        end
    endtask

    task automatic test_empty();
        clear_cfg();
        launch();
        wait_done(20);
        total++;
        if (done_cyc !== t0 + 2) begin
            bad++;
            $display("FAIL empty_done got=%0d required=%0d", done_cyc, t0 + 2);
        end
        total++;
        if (busy_cnt !== 2 || rd_cnt !== 0 || out_cnt !== 0) begin
            bad++;
            $display("FAIL empty_activity got busy=%0d rd=%0d out=%0d required busy=2 rd=0 out=0",
                     busy_cnt, rd_cnt, out_cnt);
        end
    endtask

    task automatic test_clamp();
        clear_cfg();
        cfg[3] = 127;
        launch();
        wait_done(200);
        total++;
        if (rd_cnt !== 64 || out_cnt !== 64 || last_cyc !== last_out) begin
            bad++;
            $display("FAIL clamp_count got rd=%0d out=%0d last=%0d required rd=64 out=64 last=%0d",
                     rd_cnt, out_cnt, last_cyc, last_out);
        end
        total++;
        if (done_cyc !== t0 + 69) begin
            bad++;
            $display("FAIL clamp_done got=%0d required=%0d", done_cyc, t0 + 69);
        end
    endtask

    task automatic test_overlap();
        clear_cfg();
        cfg[0] = 3; cfg[2] = 4;
        launch();
        repeat (4) @(negedge clk);
        nent_flat = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        total++;
        if (ovl_cnt !== 1 || ovl_cyc !== t0 + 6) begin
            bad++;
            $display("FAIL overlap_pulse got n=%0d cyc=%0d required n=1 cyc=%0d", ovl_cnt, ovl_cyc, t0 + 6);
        end
        total++;
        if (done_cyc !== t0 + 12 || out_cnt !== 7) begin
            bad++;
            $display("FAIL overlap_stream got done=%0d out=%0d required done=%0d out=7", done_cyc, out_cnt, t0 + 12);
        end
    endtask

    task automatic test_start_on_done();
        clear_cfg();
        cfg[4] = 1;
        launch();
        repeat (5) @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL sod_done_cycle got=%0b required=1 at cyc=%0d", done, cyc);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (ovl_cnt !== 1 || ovl_cyc !== t0 + 7 || busy !== 1'b0 || rd_cnt !== 1 || done_cnt !== 1) begin
            bad++;
            $display("FAIL sod_ignored got ovl=%0d@%0d busy=%0b rd=%0d done=%0d required ovl=1@%0d busy=0 rd=1 done=1",
                     ovl_cnt, ovl_cyc, busy, rd_cnt, done_cnt, t0 + 7);
        end
    endtask

    task automatic test_mid_reset();
        clear_cfg();
        cfg[0] = 3; cfg[7] = 5;
        launch();
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_rd.delete();
        exp_out.delete();
        @(negedge clk);
        total++;
        if ({rd_en, rd_addr, out_dat, out_valid, out_ch, out_last, busy, done, overlap_err} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got rd=%0b a=%0d d=%h v=%0b c=%0d l=%0b b=%0b dn=%0b o=%0b required all 0",
                     rd_en, rd_addr, out_dat, out_valid, out_ch, out_last, busy, done, overlap_err);
        end
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (out_cnt !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_stale got out=%0d busy=%0b required out=0 busy=0", out_cnt, busy);
        end
        test_single();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_cfg();
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_clamp();
        test_overlap();
        test_start_on_done();
        test_mid_reset();
        total++;
        if (exp_rd.size() !== 0 || exp_out.size() !== 0) begin
            bad++;
            $display("FAIL leftover got rd=%0d out=%0d required 0", exp_rd.size(), exp_out.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stream_seq.md
# mem_stream_seq

Parametrised sequencer and registered multiplexer that streams the contents of up to NCH tracklet memories onto one output bus, one entry per cycle. Unlike a plain select-driven mux, it owns the read schedule. It latches per-channel entry counts at event start, skips empty channels, drives a shared read address and compensates for memory read latency. The result is a gap-free stream tagged with channel index and last-entry flag. It sits between the per-channel memories and the downstream projection/matching stage.

## Interface
- NCH, 24: number of input channels (1..32)
- DW, 12: data width per channel
- AW, 6: memory address width; max entries per channel 2^AW
- RD_LAT, 2: memory read latency in clocks (rd_addr registered at cycle N → mem data valid at N+RD_LAT)
- CW, 5: channel index width, ≥ clog2(NCH)

- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begin event; honoured only in IDLE
- nent_flat  in  NCH*(AW+1)  entry count per channel, channel i at [i*(AW+1) +: AW+1]; sampled on accepted start
- mem_dat_flat  in  NCH*DW  memory read data, channel i at [i*DW +: DW]
- rd_en  out  1  read strobe, shared by all memories
- rd_addr  out  AW  shared read address
- out_dat  out  DW  streamed entry
- out_valid  out  1  out_dat/out_ch/out_last valid
- out_ch  out  CW  source channel of out_dat
- out_last  out  1  final entry of the event
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, event fully streamed
- overlap_err  out  1  one-cycle pulse, start received while busy

## Operation
- States: IDLE, SCAN, READ, DRAIN, DONE.
- IDLE, start=1: latch counts; clamp each to 2^AW; pending[i] = (count_i ≠ 0); busy=1; → SCAN.
- SCAN: find-first pending channel (lowest index) via combinational priority encoder. None → DONE. Else load cur_ch, addr=0, remaining=count; → READ.
- READ: rd_en=1, rd_addr=addr each cycle; addr increments.
  - At a channel's final address, clear pending[cur_ch].
  - If another channel is pending, the next cycle reads it at addr 0 with no bubble.
  - If none is pending → DRAIN.
- DRAIN: hold RD_LAT+1 cycles so the pipeline empties → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Data path:
  - {valid, ch, last} is shifted alongside rd_en through an RD_LAT-deep delay line.
  - The delayed ch selects mem_dat_flat in a registered NCH:1 mux that drives out_dat.
  - Channel indices ≥ NCH never occur; the default arm holds the previous value.
- out_last is set on the final read of the final pending channel.
- start outside IDLE: ignored, overlap_err pulses, latched counts untouched.
- Address never wraps: a count of 2^AW reads addresses 0..2^AW-1 exactly once.

## Timing
- Reset (reset_n=0 at a clock edge): state=IDLE. All outputs 0: rd_en, rd_addr, out_dat, out_valid, out_ch, out_last, busy, done, overlap_err. Delay-line valids and pending mask cleared. A mid-event reset abandons the event; no further out_valid.
- Accepted start at cycle T: SCAN at T+1, first rd_en at T+2.
- Data latency: rd_en with address A at cycle N → out_valid with that entry at N+RD_LAT+1.
- Throughput: one entry per cycle. No idle cycles between channels or within an event.
- Last rd_en at cycle L: out_last at L+RD_LAT+1, done at L+RD_LAT+2, busy low from L+RD_LAT+3.
- Empty event (all counts 0): done at T+2, no rd_en, no out_valid.
- Event length in cycles from start to done: 2 + Σcount + RD_LAT + 1 + (Σcount>0 ? 0 : −RD_LAT−1).
- start coincident with done: ignored, overlap_err=1. start is accepted from the following cycle.

## Test plan
- Defaults, ch0=3, rest 0, memory returns {ch,addr}; start at T → rd_addr 0,1,2 at T+2..T+4. out_dat 0x000,0x001,0x002 at T+5..T+7, out_ch=0, out_last only at T+7, done at T+8.
- ch1=2, ch5=1, ch23=1 → rd_en high 4 contiguous cycles. out_ch sequence 1,1,5,23 with no gaps, out_dat addresses 0,1,0,0, out_last with ch23 only.
- All counts 0 → done at T+2, busy high T+1..T+2 only, zero rd_en and out_valid.
- AW=6, ch3 count=127 → clamped. Exactly 64 reads, rd_addr 0..63 with no wrap, 64 out_valid, out_last on address 63.
- start pulsed mid-stream → overlap_err one cycle. Stream content and done timing identical to a run without the extra start.
- reset_n=0 for one cycle during READ → next cycle all outputs 0, state IDLE, no stale out_valid from the delay line. A fresh start afterwards reproduces the first scenario exactly.
